// File: rtl/fc_stream_layer.sv
// Streaming fully-connected layer: y = requant(W*x + b), LANES neurons per pass,
// weights arrive one column-slice per beat, results leave one group per handshake.

module fc_stream_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ld_bias,
  input  logic                         mac_en,
  input  logic                         req_en,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic [4:0]                   shift,
  input  logic                         relu_en,
  output logic signed [DATA_WIDTH-1:0] y
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam logic signed [AW:0] Y_MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] Y_MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   y_q, y_d;
  logic signed [2*DW-1:0] prod;
  logic signed [AW:0]     rnd, r_sum, r_sh, r_cl;

  always_comb begin
    acc_d = acc_q;
    y_d   = y_q;
    prod  = w * x;
    rnd   = '0;
    if (shift != 5'd0) rnd = (AW+1)'(1) << (shift - 5'd1);
    // One extra bit of headroom so the rounding add cannot wrap.
    r_sum = {acc_q[AW-1], acc_q} + rnd;
    r_sh  = r_sum >>> shift;
    r_cl  = (relu_en && r_sh[AW]) ? '0 : r_sh;

    if (ld_bias)     acc_d = {{(AW-DW){bias[DW-1]}}, bias};
    else if (mac_en) acc_d = acc_q + {{(AW-2*DW){prod[2*DW-1]}}, prod};

    if (req_en) begin
      if (r_cl > Y_MAX)      y_d = Y_MAX[DW-1:0];
      else if (r_cl < Y_MIN) y_d = Y_MIN[DW-1:0];
      else                   y_d = r_cl[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;
endmodule

module fc_stream_layer #(
  parameter int IN_SIZE    = 128,
  parameter int OUT_SIZE   = 64,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 24,
  localparam int GROUPS    = OUT_SIZE / LANES,
  localparam int GW        = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [IN_SIZE*DATA_WIDTH-1:0]  input_data_flat,
  input  logic [OUT_SIZE*DATA_WIDTH-1:0] bias_flat,
  input  logic                           relu_en,
  input  logic [4:0]                     shift,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [LANES*DATA_WIDTH-1:0]    w_data,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [LANES*DATA_WIDTH-1:0]    o_data,
  output logic [GW-1:0]                  o_group,
  output logic                           busy,
  output logic                           done
);
  localparam int DW = DATA_WIDTH;
  localparam int JW = $clog2(IN_SIZE);
  localparam logic [JW-1:0] J_LAST = JW'(IN_SIZE - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_REQ, S_OUT, S_DONE} state_t;

  state_t                                   state_q, state_d;
  logic [JW-1:0]                            j_q, j_d;
  logic [GW-1:0]                            g_q, g_d;
  logic [GW-1:0]                            o_group_q, o_group_d;
  logic [IN_SIZE-1:0][DW-1:0]               x_q, x_d;
  logic [GROUPS-1:0][LANES-1:0][DW-1:0]     b_q, b_d;
  logic                                     relu_q, relu_d;
  logic [4:0]                               shift_q, shift_d;
  logic [LANES-1:0][DW-1:0]                 w_lane, y_lane;
  logic                                     mac_en;

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    g_d       = g_q;
    o_group_d = o_group_q;
    x_d       = x_q;
    b_d       = b_q;
    relu_d    = relu_q;
    shift_d   = shift_q;
    case (state_q)
      S_IDLE: if (start) begin
        x_d     = input_data_flat;
        b_d     = bias_flat;
        relu_d  = relu_en;
        shift_d = shift;
        g_d     = '0;
        state_d = S_INIT;
      end
      S_INIT: begin
        j_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: if (w_valid) begin
        j_d = j_q + 1'b1;
        if (j_q == J_LAST) state_d = S_REQ;
      end
      S_REQ: begin
        o_group_d = g_q;
        state_d   = S_OUT;
      end
      S_OUT: if (o_ready) begin
        if (g_q == G_LAST) state_d = S_DONE;
        else begin
          g_d     = g_q + 1'b1;
          state_d = S_INIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      j_q       <= '0;
      g_q       <= '0;
      o_group_q <= '0;
      x_q       <= '0;
      b_q       <= '0;
      relu_q    <= 1'b0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      g_q       <= g_d;
      o_group_q <= o_group_d;
      x_q       <= x_d;
      b_q       <= b_d;
      relu_q    <= relu_d;
      shift_q   <= shift_d;
    end
  end

  assign mac_en = (state_q == S_MAC) && w_valid;
  assign w_lane = w_data;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fc_stream_lane #(.DATA_WIDTH(DW), .ACC_WIDTH(ACC_WIDTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .ld_bias (state_q == S_INIT),
      .mac_en  (mac_en),
      .req_en  (state_q == S_REQ),
      .bias    (b_q[g_q][l]),
      .w       (w_lane[l]),
      .x       (x_q[j_q]),
      .shift   (shift_q),
      .relu_en (relu_q),
      .y       (y_lane[l])
    );
  end

  // Handshake outputs decode registered state only.
  assign w_ready = (state_q == S_MAC);
  assign o_valid = (state_q == S_OUT);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign o_data  = y_lane;
  assign o_group = o_group_q;
endmodule

// File: tb/tb_fc_stream_layer.sv
// Directed bench for fc_stream_layer with IN_SIZE=4, OUT_SIZE=4, LANES=2.
module tb_fc_stream_layer;
  logic        clk = 1'b0;
  logic        reset, start, relu_en, w_valid, o_ready;
  logic [31:0] input_data_flat, bias_flat;
  logic [4:0]  shift;
  logic [15:0] w_data;
  logic        w_ready, o_valid, busy, done;
  logic [15:0] o_data;
  logic [0:0]  o_group;

  int checks = 0;
  int errors = 0;
  int done_cyc;
  logic signed [7:0] x_v [4];
  logic signed [7:0] b_v [4];
  logic signed [7:0] w_v [4][4];
  logic signed [7:0] e_v [4];

  fc_stream_layer #(.IN_SIZE(4), .OUT_SIZE(4), .DATA_WIDTH(8), .LANES(2), .ACC_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .start(start), .input_data_flat(input_data_flat),
    .bias_flat(bias_flat), .relu_en(relu_en), .shift(shift), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .o_group(o_group), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < 4; i++) begin
      input_data_flat[i*8 +: 8] = x_v[i];
      bias_flat[i*8 +: 8]       = b_v[i];
    end
  endtask

  task automatic set_all_w(input logic signed [7:0] v);
    for (int n = 0; n < 4; n++)
      for (int j = 0; j < 4; j++) w_v[n][j] = v;
  endtask

  task automatic run_job(input string tag, input logic relu, input logic [4:0] sh,
                         input bit gaps, input bit stall, input bit stray, input int exp_done);
    int cyc, grp, beat, scnt;
    bit seen;
    logic [15:0] hold_d;
    logic [0:0]  hold_g;
    @(negedge clk);
    pack_ops();
    relu_en = relu; shift = sh; start = 1'b1; w_valid = 1'b0; o_ready = !stall;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; grp = 0; beat = 0; scnt = 0; seen = 0; done_cyc = 0;
    hold_d = '0; hold_g = '0;
    chk({tag, " busy_rise"}, busy, 1);
    while (cyc < 400 && done_cyc == 0) begin
      start = 1'b0;
      if (done) done_cyc = cyc;
      if (stray && cyc == 3) begin
        input_data_flat = '1;
        start = 1'b1;
      end
      w_valid = 1'b0;
      if (w_ready && grp < 2) begin
        w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int l = 0; l < 2; l++) w_data[l*8 +: 8] = w_v[grp*2+l][beat];
        if (w_valid) beat = (beat + 1) % 4;
      end
      if (o_valid) begin
        if (!seen) begin
          seen = 1;
          chk($sformatf("%s group%0d idx", tag, grp), o_group, grp);
          for (int l = 0; l < 2; l++)
            chk($sformatf("%s y[%0d]", tag, grp*2+l), $signed(o_data[l*8 +: 8]), e_v[(grp*2+l) % 4]);
          hold_d = o_data; hold_g = o_group;
          scnt = stall ? 5 : 0;
        end else begin
          chk({tag, " hold_data"}, o_data, hold_d);
          chk({tag, " hold_group"}, o_group, hold_g);
        end
        o_ready = (scnt == 0);
        if (scnt > 0) scnt--;
        if (o_ready) begin grp++; seen = 0; end
      end else o_ready = !stall;
      @(negedge clk);
      cyc++;
    end
    if (exp_done > 0) chk({tag, " done_latency"}, done_cyc, exp_done);
    else              chk({tag, " done_seen"}, done_cyc > 0, 1);
    chk({tag, " groups_out"}, grp, 2);
    chk({tag, " busy_fall"}, busy, 0);
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; shift = '0; w_valid = 1'b0; o_ready = 1'b0;
    w_data = '0; input_data_flat = '0; bias_flat = '0;
    repeat (2) @(negedge clk);
    chk("rst w_ready", w_ready, 0);
    chk("rst o_valid", o_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst o_data", o_data, 0);
    chk("rst o_group", o_group, 0);
    reset = 1'b0;

    // Sum of ones: every neuron = 4.
    for (int i = 0; i < 4; i++) begin x_v[i] = 1; b_v[i] = 0; e_v[i] = 4; end
    set_all_w(1);
    run_job("ones", 1'b0, 5'd0, 0, 0, 0, 15);

    // Saturation: 64643 -> 127, -65024 -> -128, -5 passes, 508 -> 127.
    for (int i = 0; i < 4; i++) x_v[i] = 127;
    for (int j = 0; j < 4; j++) begin
      w_v[0][j] = 127; w_v[1][j] = -128; w_v[2][j] = 0; w_v[3][j] = 1;
    end
    b_v[0] = 127; b_v[1] = 0; b_v[2] = -5; b_v[3] = 0;
    e_v[0] = 127; e_v[1] = -128; e_v[2] = -5; e_v[3] = 127;
    run_job("sat", 1'b0, 5'd0, 0, 0, 0, 15);

    // Rounding, shift=2: 6->2, 5->1, -6->-1, -7->-2.
    for (int i = 0; i < 4; i++) x_v[i] = 1;
    set_all_w(0);
    b_v[0] = 6; b_v[1] = 5; b_v[2] = -6; b_v[3] = -7;
    e_v[0] = 2; e_v[1] = 1; e_v[2] = -1; e_v[3] = -2;
    run_job("round", 1'b0, 5'd2, 0, 0, 0, 15);

    // Mixed MAC with shift=0: acc = -3, -20, 10, 0.
    x_v[0] = 1; x_v[1] = 2; x_v[2] = 3; x_v[3] = 4;
    w_v[0][0] = 1; w_v[0][1] = -1; w_v[0][2] = 0; w_v[0][3] = 0;
    w_v[1][0] = 0; w_v[1][1] = 0;  w_v[1][2] = 0; w_v[1][3] = -5;
    for (int j = 0; j < 4; j++) begin w_v[2][j] = 2; w_v[3][j] = -1; end
    b_v[0] = -2; b_v[1] = 0; b_v[2] = -10; b_v[3] = 10;
    e_v[0] = -3; e_v[1] = -20; e_v[2] = 10; e_v[3] = 0;
    run_job("relu_off", 1'b0, 5'd0, 0, 0, 0, 15);
    e_v[0] = 0; e_v[1] = 0;
    run_job("relu_on", 1'b1, 5'd0, 0, 0, 0, 15);

    // Same job under weight gaps, output stalls and a stray start.
    e_v[0] = -3; e_v[1] = -20;
    run_job("bp", 1'b0, 5'd0, 1, 1, 1, 0);

    // Abort during group 1 MAC, then a fresh job.
    for (int i = 0; i < 4; i++) begin x_v[i] = 1; b_v[i] = 0; end
    @(negedge clk);
    pack_ops(); relu_en = 1'b0; shift = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1; o_ready = 1'b1; w_data = 16'h0101;
    repeat (9) @(negedge clk);
    chk("abort in_mac", w_ready, 1);
    chk("abort prior_data", o_data, 16'h0404);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; w_valid = 1'b0;
    chk("abort w_ready", w_ready, 0);
    chk("abort o_valid", o_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort o_data", o_data, 0);
    chk("abort o_group", o_group, 0);
    dcnt = 0;
    repeat (20) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("abort no_done", dcnt, 0);
    set_all_w(0);
    b_v[0] = 6; b_v[1] = 5; b_v[2] = -6; b_v[3] = -7;
    e_v[0] = 2; e_v[1] = 1; e_v[2] = -1; e_v[3] = -2;
    run_job("post_abort", 1'b0, 5'd2, 0, 0, 0, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
